// File: rtl/data_mem_if.sv
// data_mem_if: load/store request and response bundle between core and data memory.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );
    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory with valid/ready requests, wait states and sized loads/stores.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input logic       clk,
    input logic       reset,
    data_mem_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        wr_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] off, word, shifted, ext, wbus;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic        illegal, oor, mis, err, do_wr;
    // Base is word-aligned, so off[1:0] equals the byte lane of the request address.
    assign off     = addr_q - ADDR_BASE;
    assign idx     = off[AW+1:2];
    assign illegal = wr_q ? f3_q > 3'd2 : (f3_q == 3'd3 || f3_q > 3'd5);
    assign oor     = off >= SPAN;
    assign mis     = (f3_q[1:0] == 2'd1 && off[0]) || (f3_q[1:0] == 2'd2 && off[1:0] != 2'd0);
    assign err     = illegal | oor | mis;
    assign do_wr   = state == ACCESS && wr_q && !err;
    assign word    = mem[idx];
    assign shifted = word >> {off[1:0], 3'b000};
    assign ext     = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                     f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : shifted;
    assign be      = f3_q[1:0] == 2'd0 ? 4'b0001 << off[1:0] :
                     f3_q[1:0] == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wbus    = f3_q[1:0] == 2'd0 ? {4{wdata_q[7:0]}} :
                     f3_q[1:0] == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE   ? (bus.req_valid ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE) :
                   state == WAIT   ? (cnt == 4'd0 ? ACCESS : WAIT) :
                   state == ACCESS ? RESP : IDLE;
    end
    always_comb begin
        bus.req_ready  = state == IDLE;
        bus.busy       = state != IDLE || bus.req_valid;
        bus.resp_valid = state == RESP;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                wr_q    <= bus.req_write;
                f3_q    <= bus.req_func3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                cnt     <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
            end
            if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (state == ACCESS) begin
                rdata_q <= (err || wr_q) ? 32'd0 : ext;
                err_q   <= err;
            end
            if (state == RESP) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wbus[8*i +: 8];
    end
endmodule
